// File: rtl/test_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_mod_pkg
// Description : Shared types, vector constants and the reference AND function
//               for the 2-input AND stimulus driver / response checker.
// Revision    : 1.0 - initial release
// ============================================================================
package test_mod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] VEC_00 = 2'b00;
    localparam logic [1:0] VEC_01 = 2'b01;
    localparam logic [1:0] VEC_10 = 2'b10;
    localparam logic [1:0] VEC_11 = 2'b11;

    // vec[1] drives inA, vec[0] drives inB.
    function automatic logic exp_and(input logic [1:0] vec);
        return vec[1] & vec[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_mod_vec_seq.sv
`default_nettype none
// ============================================================================
// Module      : test_mod_vec_seq
// Description : Hold / vector / pass counters that step through the four AND
//               input vectors and flag the sample and final cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module test_mod_vec_seq
    import test_mod_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int SAMPLE_AT   = 2,
    parameter int PASSES      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_run,
    output logic [1:0] o_vec,
    output logic       o_sample_strobe,
    output logic       o_last_strobe
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [HOLD_W-1:0] c_hold_last   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_sample = HOLD_W'(SAMPLE_AT);
    localparam logic [PASS_W-1:0] c_pass_last   = PASS_W'(PASSES - 1);
    localparam logic [HOLD_W-1:0] c_hold_one    = HOLD_W'(1);
    localparam logic [PASS_W-1:0] c_pass_one    = PASS_W'(1);

    logic [HOLD_W-1:0] r_hold;
    logic [PASS_W-1:0] r_pass;
    logic [1:0]        r_vec;

    logic w_hold_end;
    logic w_vec_end;
    logic w_pass_end;

    assign w_hold_end = (r_hold == c_hold_last);
    assign w_vec_end  = (r_vec == VEC_11);
    assign w_pass_end = (r_pass == c_pass_last);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_hold <= '0;
            r_vec  <= VEC_00;
            r_pass <= '0;
        end else if (i_run) begin
            if (w_hold_end) begin
                r_hold <= '0;
                // On the final vector of the final pass the vector index stays at 3.
                if (w_vec_end && !w_pass_end) begin
                    r_vec  <= VEC_00;
                    r_pass <= r_pass + c_pass_one;
                end else if (!w_vec_end) begin
                    r_vec <= r_vec + 2'd1;
                end
            end else begin
                r_hold <= r_hold + c_hold_one;
            end
        end
    end

    assign o_vec           = r_vec;
    assign o_sample_strobe = i_run && (r_hold == c_hold_sample);
    assign o_last_strobe   = i_run && w_hold_end && w_vec_end && w_pass_end;

endmodule
`default_nettype wire

// File: rtl/test_mod_stim_chk.sv
`default_nettype none
// ============================================================================
// Module      : test_mod_stim_chk
// Description : Drives all four input vectors into a 2-input AND under test,
//               samples its response and counts mismatches (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module test_mod_stim_chk
    import test_mod_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int SAMPLE_AT   = 2,
    parameter int PASSES      = 4,
    parameter int ERR_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_out,
    output logic             o_inA,
    output logic             o_inB,
    output logic [1:0]       o_vec_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam logic [ERR_W-1:0] c_err_max = '1;
    localparam logic [ERR_W-1:0] c_err_one = ERR_W'(1);

    generate
        if ((HOLD_CYCLES < 1) || (PASSES < 1) || (SAMPLE_AT >= HOLD_CYCLES)) begin : g_param_check
            $error("test_mod_stim_chk: need HOLD_CYCLES>=1, PASSES>=1, SAMPLE_AT<HOLD_CYCLES");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_start;
    logic             w_run;
    logic [1:0]       w_vec;
    logic             w_sample;
    logic             w_last;
    logic             w_mismatch;

    test_mod_vec_seq #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .SAMPLE_AT   (SAMPLE_AT),
        .PASSES      (PASSES)
    ) u_vec_seq (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_clear         (w_start),
        .i_run           (w_run),
        .o_vec           (w_vec),
        .o_sample_strobe (w_sample),
        .o_last_strobe   (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_run = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_mismatch = (i_out != exp_and(w_vec));

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start) begin
            r_err_cnt <= '0;
        end else if (w_sample && w_mismatch && (r_err_cnt != c_err_max)) begin
            r_err_cnt <= r_err_cnt + c_err_one;
        end
    end

    // Every output is a decode of registered state only.
    assign o_busy    = (r_state == ST_DRIVE);
    assign o_done    = (r_state == ST_DONE);
    assign o_pass    = o_done && (r_err_cnt == '0);
    assign o_inA     = o_busy & w_vec[1];
    assign o_inB     = o_busy & w_vec[0];
    assign o_vec_idx = w_vec;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_mod_stim_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_mod_stim_chk
// Description : Self-checking bench: a behavioural AND model with selectable
//               faults feeds two checker instances (ERR_W=8 and ERR_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_mod_stim_chk;

    localparam int HOLD   = 4;
    localparam int SAMP   = 2;
    localparam int PASSES = 4;
    localparam int RUN    = 4 * HOLD * PASSES;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dut_out = 1'b0;
    int         mode = 0;

    logic       inA, inB, busy, done, pass;
    logic [1:0] vidx;
    logic [7:0] err;
    logic       inA3, inB3, busy3, done3, pass3;
    logic [1:0] vidx3;
    logic [2:0] err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_mod_stim_chk #(.HOLD_CYCLES(HOLD), .SAMPLE_AT(SAMP), .PASSES(PASSES), .ERR_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_out(dut_out),
        .o_inA(inA), .o_inB(inB), .o_vec_idx(vidx), .o_busy(busy),
        .o_done(done), .o_pass(pass), .o_err_cnt(err)
    );

    test_mod_stim_chk #(.HOLD_CYCLES(HOLD), .SAMPLE_AT(SAMP), .PASSES(PASSES), .ERR_W(3)) dut_w3 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_out(dut_out),
        .o_inA(inA3), .o_inB(inB3), .o_vec_idx(vidx3), .o_busy(busy3),
        .o_done(done3), .o_pass(pass3), .o_err_cnt(err3)
    );

    // Module under test: registered AND (1-cycle latency) with optional faults.
    always @(posedge clk) begin
        case (mode)
            0:       dut_out <= inA & inB;
            1:       dut_out <= 1'b0;
            2:       dut_out <= 1'b1;
            3:       dut_out <= ~(inA & inB);
            default: dut_out <= (inA & inB) ^ ($urandom_range(0, 3) == 0);
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_out"}, {busy, done, pass, inA, inB, vidx}, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_out3"}, {busy3, done3, pass3, inA3, inB3, vidx3}, 0);
        check_val({tag, "_err3"}, err3, 0);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Called at a negedge; rst_at < 0 means run to completion.
    task automatic do_run(input int m, input bit hold_start, input int rst_at);
        int mism;
        int vk;
        mode  = m;
        mism  = 0;
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < RUN; k++) begin
            vk = (k / HOLD) % 4;
            check_val("busy", {busy, done, busy3, done3}, 4'b1010);
            check_val("drive", {inA, inB, vidx}, (vk << 2) | vk);
            check_val("drive3", {inA3, inB3, vidx3}, (vk << 2) | vk);
            check_val("err_run", err, sat(mism, 255));
            check_val("err3_run", err3, sat(mism, 7));
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_idle("midrst");
                rst = 1'b0;
                return;
            end
            if ((k % HOLD) == SAMP && dut_out !== (vk == 3)) mism++;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("end_state", {busy, done, pass}, {2'b01, (mism == 0)});
        check_val("end_state3", {busy3, done3, pass3}, {2'b01, (mism == 0)});
        check_val("end_drive", {inA, inB, inA3, inB3}, 0);
        check_val("err_final", err, sat(mism, 255));
        check_val("err3_final", err3, sat(mism, 7));
        @(negedge clk);
        check_val("done_hold", {busy, done, err}, {2'b01, 8'(sat(mism, 255))});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("idle");

        do_run(0, 1'b0, -1);   // ideal: pass
        check_val("ideal_err", err, 0);
        do_run(1, 1'b0, -1);   // stuck-at-0
        check_val("stuck0_err", err, 4);
        do_run(2, 1'b0, -1);   // stuck-at-1, then restart from DONE
        check_val("stuck1_err", err, 12);
        do_run(3, 1'b1, -1);   // inverted, start held high
        check_val("inv_err", {err, err3}, {8'd16, 3'd7});
        do_run(0, 1'b0, 20);   // reset mid-run
        do_run(0, 1'b0, -1);
        check_val("post_rst_pass", {pass, pass3}, 2'b11);
        for (int r = 0; r < 4; r++) begin
            do_run(4, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
